// File: rtl/issue_queue_inorder_pkg.sv
// Shared types and sizing constants for the in-order issue queues (ALU and MEM pipes).
package issue_queue_inorder_pkg;

    localparam int ISSQ_DEPTH_ALU = 8;
    localparam int ISSQ_DEPTH_MEM = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  uop;
        logic        has_rd;
        logic        has_rs1;
        logic        has_rs2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } queue_item_t;

endpackage

// File: rtl/issue_queue_inorder_if.sv
// Dispatch-side push, register-read-side issue, and scoreboard busy vector for one issue queue.
interface issue_queue_inorder_if
    import issue_queue_inorder_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             flush;
    logic             push_valid;
    queue_item_t      push_item;
    logic             push_ready;
    logic             issue_valid;
    queue_item_t      issue_item;
    logic             issue_ready;
    logic [31:0]      busy_vec;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;

    modport master (
        output flush, push_valid, push_item, issue_ready, busy_vec,
        input  push_ready, issue_valid, issue_item, count, empty, full
    );

    modport slave (
        input  flush, push_valid, push_item, issue_ready, busy_vec,
        output push_ready, issue_valid, issue_item, count, empty, full
    );

endinterface

// File: rtl/issue_queue_inorder_operand_ready_check.sv
// Head-entry hazard check: sources (RAW) and destination (WAW) must not have a pending write.
module operand_ready_check (
    input  logic        has_rd,
    input  logic        has_rs1,
    input  logic        has_rs2,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] busy_vec,
    output logic        ready
);
    logic rs1_ok;
    logic rs2_ok;
    logic rd_ok;

    // x0 is hardwired to zero, so its busy flag is ignored.
    assign rs1_ok = !has_rs1 || (rs1 == 5'd0) || !busy_vec[rs1];
    assign rs2_ok = !has_rs2 || (rs2 == 5'd0) || !busy_vec[rs2];
    assign rd_ok  = !has_rd  || (rd  == 5'd0) || !busy_vec[rd];

    assign ready = rs1_ok && rs2_ok && rd_ok;

endmodule

// File: rtl/issue_queue_inorder.sv
// In-order issue queue: circular FIFO whose head issues only when its registers are not busy.
module issue_queue_inorder
    import issue_queue_inorder_pkg::*;
#(
    parameter  int DEPTH = ISSQ_DEPTH_ALU,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    issue_queue_inorder_if.slave  q
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    queue_item_t      mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   cnt;

    logic        full;
    logic        empty;
    logic        push_fire;
    logic        pop_fire;
    logic        head_ready;
    queue_item_t head_item;

    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign head_item = mem[head_ptr];

    operand_ready_check u_ready (
        .has_rd   (head_item.has_rd),
        .has_rs1  (head_item.has_rs1),
        .has_rs2  (head_item.has_rs2),
        .rd       (head_item.rd),
        .rs1      (head_item.rs1),
        .rs2      (head_item.rs2),
        .busy_vec (q.busy_vec),
        .ready    (head_ready)
    );

    // push_ready comes from the registered count only; a same-cycle pop does not free a slot.
    assign push_fire = q.push_valid && !full && !q.flush;
    assign pop_fire  = !empty && !q.flush && head_ready && q.issue_ready;

    assign q.push_ready  = !full;
    assign q.issue_valid = !empty && !q.flush && head_ready;
    assign q.issue_item  = head_item;
    assign q.count       = cnt;
    assign q.empty       = empty;
    assign q.full        = full;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else begin
            if (push_fire) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop_fire)  head_ptr <= head_ptr + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: entry storage has no reset; the pointers and count alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push_fire) mem[tail_ptr] <= q.push_item;
    end

endmodule

// File: tb/tb_issue_queue_inorder.sv
// Directed self-checking bench for issue_queue_inorder with DEPTH = 8.
module tb_issue_queue_inorder;
    import issue_queue_inorder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    issue_queue_inorder_if #(.DEPTH(8)) q ();

    issue_queue_inorder #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic queue_item_t make_item(input logic [31:0] pc,
                                              input logic hrd, input logic [4:0] rd,
                                              input logic hrs1, input logic [4:0] rs1);
        queue_item_t it;
        it         = '0;
        it.pc      = pc;
        it.uop     = pc[9:2];
        it.has_rd  = hrd;
        it.rd      = rd;
        it.has_rs1 = hrs1;
        it.rs1     = rs1;
        return it;
    endfunction

    // Present an entry across one rising edge.
    task automatic push_one(input queue_item_t it);
        @(negedge clk);
        q.push_valid = 1'b1;
        q.push_item  = it;
        @(posedge clk);
    endtask

    // Drop push/flush and let combinational outputs settle before checking.
    task automatic idle();
        @(negedge clk);
        q.push_valid = 1'b0;
        q.flush      = 1'b0;
        #1;
    endtask

    initial begin
        q.flush       = 1'b0;
        q.push_valid  = 1'b0;
        q.push_item   = '0;
        q.issue_ready = 1'b0;
        q.busy_vec    = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("rst_empty", 32'(q.empty), 32'd1);
        check("rst_full", 32'(q.full), 32'd0);
        check("rst_count", 32'(q.count), 32'd0);
        check("rst_issue_valid", 32'(q.issue_valid), 32'd0);
        check("rst_push_ready", 32'(q.push_ready), 32'd1);

        // Fill to DEPTH with issue blocked by issue_ready = 0
        for (int i = 0; i < 8; i++) push_one(make_item(32'h100 + 32'(4*i), 1'b0, 5'd0, 1'b0, 5'd0));
        idle();
        check("fill_full", 32'(q.full), 32'd1);
        check("fill_push_ready", 32'(q.push_ready), 32'd0);
        check("fill_count", 32'(q.count), 32'd8);
        push_one(make_item(32'h200, 1'b0, 5'd0, 1'b0, 5'd0));
        idle();
        check("ninth_refused_count", 32'(q.count), 32'd8);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            q.issue_ready = 1'b1;
            #1;
            check($sformatf("drain_valid_%0d", i), 32'(q.issue_valid), 32'd1);
            check($sformatf("drain_pc_%0d", i), q.issue_item.pc, 32'h100 + 32'(4*i));
        end
        idle();
        check("drain_empty", 32'(q.empty), 32'd1);
        check("drain_issue_valid", 32'(q.issue_valid), 32'd0);

        // RAW on rs1 = 5
        q.busy_vec = 32'h0000_0020;
        push_one(make_item(32'h500, 1'b0, 5'd0, 1'b1, 5'd5));
        idle();
        check("raw_blocked", 32'(q.issue_valid), 32'd0);
        idle();
        check("raw_blocked_count", 32'(q.count), 32'd1);
        q.busy_vec = 32'h0;
        #1;
        check("raw_clear_same_cycle", 32'(q.issue_valid), 32'd1);
        idle();
        check("raw_popped", 32'(q.empty), 32'd1);

        // rs1 = x0 ignores busy_vec[0]
        q.busy_vec = 32'h0000_0001;
        push_one(make_item(32'h504, 1'b0, 5'd0, 1'b1, 5'd0));
        idle();
        check("x0_issues", 32'(q.issue_valid), 32'd1);
        check("x0_pc", q.issue_item.pc, 32'h504);
        idle();
        check("x0_popped", 32'(q.count), 32'd0);
        q.busy_vec = 32'h0;

        // Steady push+pop with wrap-around
        @(negedge clk);
        q.push_valid = 1'b1;
        q.push_item  = make_item(32'h300, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        check("wrap_no_bypass", 32'(q.issue_valid), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            q.push_item = make_item(32'h300 + 32'(4*i), 1'b0, 5'd0, 1'b0, 5'd0);
            #1;
            check($sformatf("wrap_count_%0d", i), 32'(q.count), 32'd1);
            check($sformatf("wrap_pc_%0d", i), q.issue_item.pc, 32'h300 + 32'(4*(i-1)));
        end
        idle();
        check("wrap_last_pc", q.issue_item.pc, 32'h350);
        idle();
        check("wrap_drained", 32'(q.empty), 32'd1);

        // Flush with a same-cycle push
        q.issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(make_item(32'h600 + 32'(4*i), 1'b0, 5'd0, 1'b0, 5'd0));
        idle();
        check("pre_flush_count", 32'(q.count), 32'd4);
        @(negedge clk);
        q.flush      = 1'b1;
        q.push_valid = 1'b1;
        q.push_item  = make_item(32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        check("flush_issue_valid", 32'(q.issue_valid), 32'd0);
        idle();
        check("post_flush_count", 32'(q.count), 32'd0);
        check("post_flush_empty", 32'(q.empty), 32'd1);
        q.issue_ready = 1'b1;
        push_one(make_item(32'h700, 1'b0, 5'd0, 1'b0, 5'd0));
        idle();
        check("post_flush_head_pc", q.issue_item.pc, 32'h700);
        idle();
        check("post_flush_drained", 32'(q.empty), 32'd1);

        // WAW on rd = 7 blocks a younger independent entry
        q.busy_vec = 32'h0000_0080;
        push_one(make_item(32'h800, 1'b1, 5'd7, 1'b0, 5'd0));
        push_one(make_item(32'h804, 1'b0, 5'd0, 1'b0, 5'd0));
        idle();
        check("waw_blocked", 32'(q.issue_valid), 32'd0);
        idle();
        check("waw_younger_blocked", 32'(q.count), 32'd2);
        q.busy_vec = 32'h0;
        #1;
        check("waw_release_pc", q.issue_item.pc, 32'h800);
        idle();
        check("waw_younger_pc", q.issue_item.pc, 32'h804);
        check("waw_younger_valid", 32'(q.issue_valid), 32'd1);
        idle();
        check("waw_drained", 32'(q.empty), 32'd1);

        // Reset mid-operation
        q.issue_ready = 1'b0;
        push_one(make_item(32'h900, 1'b0, 5'd0, 1'b0, 5'd0));
        push_one(make_item(32'h904, 1'b0, 5'd0, 1'b0, 5'd0));
        @(negedge clk);
        q.push_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_count", 32'(q.count), 32'd0);
        check("midrst_push_ready", 32'(q.push_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
